// File: rtl/md_unit_if.sv
// Bus between the EX-stage controls and the multiply/divide unit.
// Optional MD_ABORT_EN adds the Abort flush input after B.
interface md_unit_if;
    logic        Start;
    logic [3:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
`ifdef MD_ABORT_EN
    logic        Abort;
`endif
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDOut;

`ifdef MD_ABORT_EN
    modport master (output Start, MDOp, A, B, Abort, input Busy, HI, LO, MDOut);
    modport slave  (input Start, MDOp, A, B, Abort, output Busy, HI, LO, MDOut);
`else
    modport master (output Start, MDOp, A, B, input Busy, HI, LO, MDOut);
    modport slave  (input Start, MDOp, A, B, output Busy, HI, LO, MDOut);
`endif
endinterface

// File: rtl/md_unit.sv
// Multi-cycle MIPS multiply/divide unit holding HI/LO; result is computed at launch and committed after N cycles.
// Define MD_ABORT_EN to add the Abort input that flushes an in-flight operation.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic     clk,
    input  logic     reset,
    md_unit_if.slave md
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam logic [31:0] MULT_LOAD = 32'(MULT_CYCLES);
    localparam logic [31:0] DIV_LOAD  = 32'(DIV_CYCLES);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic [31:0] res_lo_q, res_lo_d;

    logic        abort;
    logic        launch;
    logic        b_zero;
    logic signed [63:0] mul_s;
    logic [63:0] mul_u;
    logic [31:0] a_mag, b_mag, sdiv_den, udiv_den;
    logic [31:0] sq_mag, sr_mag, s_quo, s_rem, u_quo, u_rem;

`ifdef MD_ABORT_EN
    assign abort = md.Abort;
`else
    assign abort = 1'b0;
`endif

    assign launch = md.Start && (md.MDOp >= OP_MULT) && (md.MDOp <= OP_DIVU);
    assign b_zero = (md.B == 32'd0);

    // Signed division works on magnitudes so that 0x80000000 / -1 needs no special case.
    always_comb begin
        mul_s    = $signed({{32{md.A[31]}}, md.A}) * $signed({{32{md.B[31]}}, md.B});
        mul_u    = {32'd0, md.A} * {32'd0, md.B};
        a_mag    = md.A[31] ? (~md.A + 32'd1) : md.A;
        b_mag    = md.B[31] ? (~md.B + 32'd1) : md.B;
        sdiv_den = b_zero ? 32'd1 : b_mag;
        udiv_den = b_zero ? 32'd1 : md.B;
        sq_mag   = a_mag / sdiv_den;
        sr_mag   = a_mag % sdiv_den;
        s_quo    = (md.A[31] ^ md.B[31]) ? (~sq_mag + 32'd1) : sq_mag;
        s_rem    = md.A[31] ? (~sr_mag + 32'd1) : sr_mag;
        u_quo    = md.A / udiv_den;
        u_rem    = md.A % udiv_den;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        case (state_q)
            IDLE: begin
                if (!abort) begin
                    if (launch) begin
                        state_d = RUN;
                        case (md.MDOp)
                            OP_MULT: begin
                                cnt_d                = MULT_LOAD;
                                {res_hi_d, res_lo_d} = mul_s;
                            end
                            OP_MULTU: begin
                                cnt_d                = MULT_LOAD;
                                {res_hi_d, res_lo_d} = mul_u;
                            end
                            OP_DIV: begin
                                cnt_d    = DIV_LOAD;
                                res_hi_d = b_zero ? hi_q : s_rem;
                                res_lo_d = b_zero ? lo_q : s_quo;
                            end
                            default: begin
                                cnt_d    = DIV_LOAD;
                                res_hi_d = b_zero ? hi_q : u_rem;
                                res_lo_d = b_zero ? lo_q : u_quo;
                            end
                        endcase
                    end else if (!md.Start && md.MDOp == OP_MTHI) begin
                        hi_d = md.A;
                    end else if (!md.Start && md.MDOp == OP_MTLO) begin
                        lo_d = md.A;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = 32'd0;
                end else if (cnt_q == 32'd1) begin
                    state_d = IDLE;
                    cnt_d   = 32'd0;
                    hi_d    = res_hi_q;
                    lo_d    = res_lo_q;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
        end
    end

    always_comb begin
        case (md.MDOp)
            OP_MFHI: md.MDOut = hi_q;
            OP_MFLO: md.MDOut = lo_q;
            default: md.MDOut = 32'd0;
        endcase
    end

    assign md.Busy = (state_q == RUN);
    assign md.HI   = hi_q;
    assign md.LO   = lo_q;

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage of the 5-stage MIPS pipeline.
- Consumes the decoded MD operation and forwarded rs/rt operands produced by the decode/controller logic.
- Holds architectural HI/LO and supplies mfhi/mflo results to the EX result mux.
- Exports Busy, which the hazard controller ORs into Stalk whenever an MD-class instruction sits in ID while Start or Busy is high.

Parameters:
- MULT_CYCLES, 5, EX cycles a mult/multu occupies (Busy-high cycles); legal range >= 1.
- DIV_CYCLES, 10, EX cycles a div/divu occupies (Busy-high cycles); legal range >= 1.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- Start  input  1  launch a mult/multu/div/divu this cycle; only meaningful with MDOp 1-4
- MDOp  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9-15 treated as NONE
- A  input  32  forwarded rs value
- B  input  32  forwarded rt value
- Busy  output  1  operation in flight
- HI  output  32  HI register
- LO  output  32  LO register
- MDOut  output  32  combinational read: HI if MDOp==5, LO if MDOp==6, else 0

Behaviour:
- Clock and reset: one clock `clk`. Reset is synchronous, active-high on `reset`.
- Reset values: state IDLE, Busy=0, HI=0, LO=0, counter=0, operand/result latches=0. Reset overrides every other input on the same edge, including mid-operation: the in-flight result is discarded.
- States and transitions:
  - IDLE -> RUN on an edge where Start=1 and MDOp is 1-4.
  - RUN -> IDLE on the edge where the counter reaches 1.
- Launch (edge k, Start=1):
  - Latch the full 64-bit result, computed from A/B at edge k. A shift-add implementation is also acceptable if the timing below is met.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Busy=1 from after edge k.
- RUN: counter decrements each edge.
  - On the edge where counter==1: write HI/LO, clear Busy, go to IDLE.
  - Busy is high for exactly N cycles, and new HI/LO is visible the same cycle Busy falls (after edge k+N).
- Arithmetic:
  - MULT: signed 32x32 -> 64. MULTU: unsigned. HI = result[63:32], LO = result[31:0].
  - DIV/DIVU: LO = quotient, HI = remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (B==0): still Busy for DIV_CYCLES, HI/LO unchanged at completion.
- MTHI/MTLO:
  - Write A into HI/LO at the next edge, only when Busy==0 and no Start is present the same cycle.
  - If Busy==1 the write is ignored. The hazard controller guarantees this never happens architecturally.
- Start while Busy=1: ignored (no relaunch, counter untouched).
- Start with MDOp outside 1-4: ignored.
- MDOp NONE or 9-15: no state change.
- MDOut during RUN returns the old HI/LO. The hazard controller stalls mf* while Busy, so this is a don't-care architecturally, but the value is still defined.

Optional Feature:
- Macro: MD_ABORT_EN.
- When defined:
  - Adds input port `Abort` (1 bit), placed after `B`. Used for exception flush of a speculative MD instruction.
  - Abort=1 at an edge while in RUN: return to IDLE, Busy=0 after that edge, HI/LO unchanged.
  - Abort=1 in the same cycle as Start in IDLE: the launch is suppressed.
  - Abort=1 has priority over MTHI/MTLO, which are suppressed in that cycle.
  - Reset still has priority over Abort.
- When undefined: port absent; operations always run to completion unless reset.

Test Plan:
- MULT, A=0xFFFFFFFE (-2), B=3, Start at edge 0 -> Busy=1 after edges 0-4, Busy=0 after edge 5, HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=-7 (0xFFFFFFF9), B=2 -> after DIV_CYCLES, LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU same operands -> LO=0x7FFFFFFC, HI=1.
- Preload HI=0x11, LO=0x22 via MTHI/MTLO, then DIV with B=0 -> Busy for 10 cycles, then HI=0x11, LO=0x22; MFHI then returns MDOut=0x11.
- Start a MULT, reassert Start with DIV at cycle 2, and assert MTLO A=0x55 at cycle 3 -> both ignored; the original MULT result lands at cycle 5.
- Assert reset at cycle 3 of a DIV -> Busy=0, HI=LO=0 next cycle; a new MULT 6x7 afterwards -> LO=42, HI=0.
- With MD_ABORT_EN defined, assert Abort at cycle 2 of a MULT with HI=LO=0x9 -> Busy=0 next cycle, HI=LO=0x9; Start+Abort in the same cycle -> Busy stays 0.
